rx: RTL and testbench

UART receive block with an integrated receive FIFO. It samples the serial line `rx_data_in` at 8x the bit rate, deserializes 8N1 frames (LSB first), and pushes each valid byte into a small FIFO. The host side drains the FIFO through a level-sensitive `rx_req` read request and the `rx_empty` flag. It is the receive half of the custom UART, clocked by the 8x-oversample clock `rx_clk`.

---
 rtl/rx.sv | 141 ++++++++++++++
 tb/tb_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rx.sv
// UART receiver for 8N1 frames sampled on an 8x oversample clock, with a
// small circular receive FIFO drained by a level-sensitive read request.
module rx #(
  parameter int DEPTH = 8
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       rx_data_in,
  input  logic       rx_en,
  input  logic       rx_req,
  output logic [7:0] rx_data_out,
  output logic       rx_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [2:0]    r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic [2:0]    r_pre;
  logic [7:0]    r_dataOut;
  logic          r_empty;

  logic w_line;
  logic w_stopSample;
  logic w_full;
  logic w_push;
  logic w_pop;

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_data_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line       = r_sync2;
  assign w_stopSample = rx_en && (r_state == STOP) && (r_cnt == 3'd7);
  assign w_full       = (r_count == FULL_COUNT);
  assign w_push       = w_stopSample && w_line && !w_full;
  assign w_pop        = rx_req && (r_pre == 3'd7) && (r_count != '0);

  // Receive FSM: mid-bit sampling at counter 3 for the start bit, then every
  // 8th cycle, so the data/stop samples land near the centre of each bit.
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_bitIdx <= 3'd0;
      r_shift  <= 8'h00;
    end else if (!rx_en) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_line) begin
            r_state <= START;
            r_cnt   <= 3'd0;
          end
        end
        START: begin
          if (r_cnt == 3'd3) begin
            r_cnt    <= 3'd0;
            r_bitIdx <= 3'd0;
            r_state  <= w_line ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        DATA: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_shift  <= {w_line, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
            if (r_bitIdx == 3'd7) begin
              r_state <= STOP;
            end
          end
        end
        STOP: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= r_shift;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_pre     <= 3'd0;
      r_dataOut <= 8'h00;
      r_empty   <= 1'b1;
    end else begin
      r_pre   <= r_pre + 3'd1;
      r_empty <= (r_count == '0);
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_dataOut <= r_mem[r_rdPtr];
        r_rdPtr   <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_data_out = r_dataOut;
  assign rx_empty    = r_empty;

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: table-driven frames, hand-built corner cases and
// random frames checked against a byte-queue model of the receiver.
module tb_rx;

  localparam int DEPTH = 8;

  logic       rx_clk;
  logic       rst;
  logic       rx_data_in;
  logic       rx_en;
  logic       rx_req;
  logic [7:0] rx_data_out;
  logic       rx_empty;

  int nChecks = 0;
  int nPass   = 0;

  logic [7:0] modelQ [$];
  logic [7:0] lastOut = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         abortBit;
    logic       expectPush;
  } vec_t;

  vec_t vecs [7];

  rx #(.DEPTH(DEPTH)) dut (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .rx_data_in  (rx_data_in),
    .rx_en       (rx_en),
    .rx_req      (rx_req),
    .rx_data_out (rx_data_out),
    .rx_empty    (rx_empty)
  );

  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rx_clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nChecks++;
    if (actual === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One 8N1 frame, LSB first; abortBit >= 0 drops rx_en from that data bit
  // until the line has returned to idle.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int abortBit, input int gap);
    rx_data_in = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      if (i == abortBit) rx_en = 1'b0;
      rx_data_in = data[i];
      tick(8);
    end
    rx_data_in = stopBit;
    tick(8);
    rx_data_in = 1'b1;
    tick(gap);
    if (abortBit >= 0) begin
      tick(16);
      rx_en = 1'b1;
    end
    if (abortBit < 0 && stopBit && modelQ.size() < DEPTH) begin
      modelQ.push_back(data);
    end
  endtask

  task automatic readOne();
    rx_req = 1'b1;
    tick(8);
    rx_req = 1'b0;
    if (modelQ.size() > 0) lastOut = modelQ.pop_front();
    checkOutput("readData", rx_data_out, lastOut);
    tick(2);
    checkOutput("emptyAfterRead", {7'b0, rx_empty}, {7'b0, modelQ.size() == 0});
  endtask

  task automatic burstRead(input int n);
    rx_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick(8);
      if (modelQ.size() > 0) lastOut = modelQ.pop_front();
      checkOutput("burstData", rx_data_out, lastOut);
      if (k < n - 1) checkOutput("burstNotEmpty", {7'b0, rx_empty}, 8'h00);
    end
    rx_req = 1'b0;
    tick(2);
    checkOutput("burstEmpty", {7'b0, rx_empty}, 8'h01);
  endtask

  initial begin
    vecs[0] = '{8'h88, 1'b1, -1, 1'b1};
    vecs[1] = '{8'h44, 1'b1, -1, 1'b1};
    vecs[2] = '{8'h22, 1'b1, -1, 1'b1};
    vecs[3] = '{8'h11, 1'b1, -1, 1'b1};
    vecs[4] = '{8'hC3, 1'b0, -1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1,  3, 1'b0};
    vecs[6] = '{8'h5A, 1'b1, -1, 1'b1};

    rst        = 1'b0;
    rx_data_in = 1'b1;
    rx_en      = 1'b1;
    rx_req     = 1'b0;
    #23;
    checkOutput("resetEmpty", {7'b0, rx_empty}, 8'h01);
    checkOutput("resetData", rx_data_out, 8'h00);
    rst = 1'b1;
    tick(100);
    checkOutput("idleNoPush", {7'b0, rx_empty}, 8'h01);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].data, vecs[v].stopBit, vecs[v].abortBit, 16);
      tick(2);
      checkOutput("tableEmpty", {7'b0, rx_empty}, {7'b0, ~vecs[v].expectPush});
      if (vecs[v].expectPush) readOne();
    end

    // A 2-cycle low pulse must be rejected at the start-bit re-sample.
    rx_data_in = 1'b0;
    tick(2);
    rx_data_in = 1'b1;
    tick(100);
    checkOutput("glitchNoPush", {7'b0, rx_empty}, 8'h01);

    applyStimulus(8'h88, 1'b1, -1, 0);
    applyStimulus(8'h44, 1'b1, -1, 0);
    applyStimulus(8'h22, 1'b1, -1, 0);
    applyStimulus(8'h11, 1'b1, -1, 4);
    burstRead(4);

    for (int b = 1; b <= 9; b++) begin
      applyStimulus(8'(b), 1'b1, -1, (b == 9) ? 4 : 0);
    end
    for (int r = 0; r < DEPTH; r++) readOne();
    readOne();

    // Asynchronous reset in the middle of a frame with two bytes stored.
    applyStimulus(8'h33, 1'b1, -1, 8);
    applyStimulus(8'hCC, 1'b1, -1, 8);
    rx_data_in = 1'b0;
    tick(8);
    rx_data_in = 1'b1;
    tick(20);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midResetEmpty", {7'b0, rx_empty}, 8'h01);
    checkOutput("midResetData", rx_data_out, 8'h00);
    modelQ.delete();
    lastOut = 8'h00;
    #10;
    rst = 1'b1;
    tick(20);
    applyStimulus(8'hA5, 1'b1, -1, 8);
    readOne();
    readOne();

    for (int n = 0; n < 24; n++) begin
      applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0), -1, 16);
      repeat ($urandom_range(0, 2)) readOne();
    end
    while (modelQ.size() > 0) readOne();
    readOne();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
